// File: rtl/decomp_window_feeder.sv
// decomp_window_feeder: parses 256-bit page beats, passes header/raw beats through,
// and aligns compressed blocks in a two-beat window, emitting one block per handshake.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_data/in_valid/in_last/in_ready   page beat input (bit 255 first in stream order)
//   out_valid/out_ready             output bundle handshake
//   concat_data                     {hi beat, lo beat}; bit offset k = concat_data[511-k]
//   cursor, bitmap, offset1..7      block bitmap position, bitmap, word payload offsets minus 16
//   is_header, need_decomp          bundle flags
//   err                             sticky truncation error
module decomp_window_feeder #(
    parameter int unsigned BEAT_W  = 256,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned SKIP_TH = 240
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BEAT_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*BEAT_W-1:0] concat_data,
    output logic [10:0]         cursor,
    output logic [15:0]         bitmap,
    output logic [10:0]         offset1,
    output logic [10:0]         offset2,
    output logic [10:0]         offset3,
    output logic [10:0]         offset4,
    output logic [10:0]         offset5,
    output logic [10:0]         offset6,
    output logic [10:0]         offset7,
    output logic                is_header,
    output logic                need_decomp,
    output logic                err
);
    localparam int unsigned POS_W = 11;
    localparam int unsigned BM_W  = 16;
    localparam int unsigned WIN_W = 2 * BEAT_W;
    localparam int unsigned NWORD = 8;

    typedef enum logic [1:0] {S_HDR, S_RAW, S_COMP, S_DRAIN} state_e;

    state_e                           state_q, state_d;
    logic [BEAT_W-1:0]                hi_q, hi_d, lo_q, lo_d;
    logic                             hi_v_q, hi_v_d, lo_v_q, lo_v_d;
    logic [POS_W-1:0]                 cur_q, cur_d, endc_q, endc_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             last_q, last_d, err_q, err_d, run_q;
    logic                             out_valid_q, out_valid_d;
    logic [WIN_W-1:0]                 concat_q, concat_d;
    logic [POS_W-1:0]                 cursor_q, cursor_d;
    logic [BM_W-1:0]                  bitmap_q, bitmap_d;
    logic [NWORD-2:0][POS_W-1:0]      offs_q, offs_d;
    logic                             is_header_q, is_header_d, need_decomp_q, need_decomp_d;

    logic [BM_W-1:0]                  blk_bm;
    logic [NWORD-2:0][POS_W-1:0]      blk_offs;
    logic [POS_W-1:0]                 acc, blk_end, cur_p;
    logic                             emit_ok, blk_hs, out_free, in_ready_c, in_acc;
    logic [BEAT_W-1:0]                hi_p, lo_p;
    logic                             hi_v_p, lo_v_p;

    function automatic logic [POS_W-1:0] code_size(input logic [1:0] code);
        case (code)
            2'b00:   code_size = POS_W'(0);
            2'b01:   code_size = POS_W'(8);
            2'b10:   code_size = POS_W'(16);
            default: code_size = POS_W'(32);
        endcase
    endfunction

    // Decode the block at the current cursor; the bitmap always lies inside the hi beat.
    always_comb begin
        blk_bm = BM_W'(hi_q >> (POS_W'(BEAT_W - BM_W) - cur_q));
        acc    = code_size(blk_bm[1:0]);
        for (int i = 1; i < NWORD; i++) begin
            blk_offs[i-1] = cur_q + acc;
            acc           = acc + code_size(blk_bm[2*i +: 2]);
        end
        blk_end = cur_q + acc + POS_W'(BM_W);
        emit_ok = hi_v_q && (lo_v_q || (blk_end <= POS_W'(BEAT_W)));
    end

    assign out_free = !out_valid_q || out_ready;
    assign blk_hs   = (state_q == S_COMP) && out_valid_q && out_ready && !is_header_q;

    // Window after this cycle's block handshake: skip past every beat the cursor has left.
    always_comb begin
        hi_p   = hi_q;
        lo_p   = lo_q;
        hi_v_p = hi_v_q;
        lo_v_p = lo_v_q;
        cur_p  = cur_q;
        if (blk_hs) begin
            cur_p = endc_q;
            for (int s = 0; s < 2; s++) begin
                if (cur_p > POS_W'(SKIP_TH)) begin
                    hi_p   = lo_p;
                    hi_v_p = lo_v_p;
                    lo_p   = '0;
                    lo_v_p = 1'b0;
                    cur_p  = (cur_p >= POS_W'(BEAT_W)) ? cur_p - POS_W'(BEAT_W) : '0;
                end
            end
        end
    end

    // Beat acceptance; held off during reset and once a compressed page has delivered its last beat.
    always_comb begin
        case (state_q)
            S_HDR, S_RAW: in_ready_c = out_free;
            S_COMP:       in_ready_c = !last_q && !(hi_v_p && lo_v_p);
            default:      in_ready_c = 1'b1;
        endcase
        in_ready_c = in_ready_c && run_q;
    end

    assign in_acc = in_valid && in_ready_c;

    // Next-state and output-register load.
    always_comb begin
        state_d       = state_q;
        hi_d          = hi_p;
        lo_d          = lo_p;
        hi_v_d        = hi_v_p;
        lo_v_d        = lo_v_p;
        cur_d         = cur_p;
        endc_d        = endc_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        err_d         = err_q;
        out_valid_d   = out_valid_q && !out_ready;
        concat_d      = concat_q;
        cursor_d      = cursor_q;
        bitmap_d      = bitmap_q;
        offs_d        = offs_q;
        is_header_d   = is_header_q;
        need_decomp_d = need_decomp_q;
        case (state_q)
            S_HDR: begin
                if (in_acc) begin
                    out_valid_d   = 1'b1;
                    concat_d      = {in_data, {BEAT_W{1'b0}}};
                    cursor_d      = '0;
                    bitmap_d      = '0;
                    offs_d        = '0;
                    is_header_d   = 1'b1;
                    need_decomp_d = in_data[BEAT_W-1];
                    hi_d          = '0;
                    lo_d          = '0;
                    hi_v_d        = 1'b0;
                    lo_v_d        = 1'b0;
                    cur_d         = '0;
                    cnt_d         = in_data[CNT_W-1:0];
                    last_d        = 1'b0;
                    if (in_last)                          state_d = S_HDR;
                    else if (!in_data[BEAT_W-1])          state_d = S_RAW;
                    else if (in_data[CNT_W-1:0] == '0)    state_d = S_DRAIN;
                    else                                  state_d = S_COMP;
                end
            end
            S_RAW: begin
                if (in_acc) begin
                    out_valid_d   = 1'b1;
                    concat_d      = {in_data, {BEAT_W{1'b0}}};
                    cursor_d      = '0;
                    bitmap_d      = '0;
                    offs_d        = '0;
                    is_header_d   = 1'b0;
                    need_decomp_d = 1'b0;
                    if (in_last) state_d = S_HDR;
                end
            end
            S_COMP: begin
                if (in_acc) begin
                    if (!hi_v_p) begin
                        hi_d   = in_data;
                        hi_v_d = 1'b1;
                    end else begin
                        lo_d   = in_data;
                        lo_v_d = 1'b1;
                    end
                    last_d = last_q || in_last;
                end
                if (blk_hs) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        hi_v_d  = 1'b0;
                        lo_v_d  = 1'b0;
                        cur_d   = '0;
                        state_d = (last_q || (in_acc && in_last)) ? S_HDR : S_DRAIN;
                    end
                end else if (!out_valid_q) begin
                    if (emit_ok) begin
                        out_valid_d   = 1'b1;
                        concat_d      = {hi_q, lo_q};
                        cursor_d      = cur_q;
                        bitmap_d      = blk_bm;
                        offs_d        = blk_offs;
                        is_header_d   = 1'b0;
                        need_decomp_d = 1'b1;
                        endc_d        = blk_end;
                    end else if (last_q) begin
                        // Page ended before the next block could be assembled.
                        err_d   = 1'b1;
                        hi_d    = '0;
                        lo_d    = '0;
                        hi_v_d  = 1'b0;
                        lo_v_d  = 1'b0;
                        cur_d   = '0;
                        state_d = S_HDR;
                    end
                end
            end
            default: begin
                if (in_acc && in_last) state_d = S_HDR;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_HDR;
            hi_q          <= '0;
            lo_q          <= '0;
            hi_v_q        <= 1'b0;
            lo_v_q        <= 1'b0;
            cur_q         <= '0;
            endc_q        <= '0;
            cnt_q         <= '0;
            last_q        <= 1'b0;
            err_q         <= 1'b0;
            run_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            concat_q      <= '0;
            cursor_q      <= '0;
            bitmap_q      <= '0;
            offs_q        <= '0;
            is_header_q   <= 1'b0;
            need_decomp_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            hi_v_q        <= hi_v_d;
            lo_v_q        <= lo_v_d;
            cur_q         <= cur_d;
            endc_q        <= endc_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            err_q         <= err_d;
            run_q         <= 1'b1;
            out_valid_q   <= out_valid_d;
            concat_q      <= concat_d;
            cursor_q      <= cursor_d;
            bitmap_q      <= bitmap_d;
            offs_q        <= offs_d;
            is_header_q   <= is_header_d;
            need_decomp_q <= need_decomp_d;
        end
    end

    assign in_ready    = in_ready_c;
    assign out_valid   = out_valid_q;
    assign concat_data = concat_q;
    assign cursor      = cursor_q;
    assign bitmap      = bitmap_q;
    assign offset1     = offs_q[0];
    assign offset2     = offs_q[1];
    assign offset3     = offs_q[2];
    assign offset4     = offs_q[3];
    assign offset5     = offs_q[4];
    assign offset6     = offs_q[5];
    assign offset7     = offs_q[6];
    assign is_header   = is_header_q;
    assign need_decomp = need_decomp_q;
    assign err         = err_q;

endmodule

// File: tb/tb_decomp_window_feeder.sv
// Self-checking bench for decomp_window_feeder: per-page tables of input beats and
// expected bundles, plus hand sequences for stall, truncation error and mid-page reset.
module tb_decomp_window_feeder;
    typedef logic [6:0][10:0] offs_t;
    typedef struct {
        logic [255:0] data;
        logic         last;
    } beat_t;
    typedef struct {
        logic [511:0] data;
        logic [10:0]  cursor;
        logic [15:0]  bitmap;
        offs_t        offs;
        logic         hdr;
        logic         nd;
        logic         chk_lo;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] in_data;
    logic         in_valid, in_last, in_ready, out_valid, out_ready;
    logic [511:0] concat_data;
    logic [10:0]  cursor, offset1, offset2, offset3, offset4, offset5, offset6, offset7;
    logic [15:0]  bitmap;
    logic         is_header, need_decomp, err;

    int n_cmp = 0;
    int n_err = 0;
    beat_t beats[$];
    exp_t  exps[$];

    decomp_window_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .concat_data(concat_data), .cursor(cursor), .bitmap(bitmap),
        .offset1(offset1), .offset2(offset2), .offset3(offset3), .offset4(offset4),
        .offset5(offset5), .offset6(offset6), .offset7(offset7),
        .is_header(is_header), .need_decomp(need_decomp), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [255:0] hdr_beat(input logic nd, input logic [15:0] n);
        logic [255:0] h;
        h        = '0;
        h[255]   = nd;
        h[15:0]  = n;
        return h;
    endfunction

    function automatic offs_t offs_step(input logic [10:0] first, input logic [10:0] step);
        offs_t o;
        for (int k = 0; k < 7; k++) o[k] = first + 11'(k) * step;
        return o;
    endfunction

    function automatic offs_t offs7(input logic [10:0] o1, o2, o3, o4, o5, o6, o7);
        offs_t o;
        o[0] = o1; o[1] = o2; o[2] = o3; o[3] = o4; o[4] = o5; o[5] = o6; o[6] = o7;
        return o;
    endfunction

    function automatic exp_t e_hdr(input logic [255:0] h);
        exp_t e;
        e.data = {h, 256'h0}; e.cursor = '0; e.bitmap = '0; e.offs = '0;
        e.hdr = 1'b1; e.nd = h[255]; e.chk_lo = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_raw(input logic [255:0] r);
        exp_t e;
        e.data = {r, 256'h0}; e.cursor = '0; e.bitmap = '0; e.offs = '0;
        e.hdr = 1'b0; e.nd = 1'b0; e.chk_lo = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_blk(input logic [255:0] hi, input logic [255:0] lo, input logic chk_lo,
                                   input logic [10:0] cur, input logic [15:0] bm, input offs_t o);
        exp_t e;
        e.data = {hi, lo}; e.cursor = cur; e.bitmap = bm; e.offs = o;
        e.hdr = 1'b0; e.nd = 1'b1; e.chk_lo = chk_lo;
        return e;
    endfunction

    task automatic add_beat(input logic [255:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        beats.push_back(b);
    endtask

    // Drive the beat table and check every handshaken bundle against the expected table.
    task automatic run(input int stall_idx);
        int bi = 0;
        int ei = 0;
        int cyc = 0;
        int st = 0;
        logic [511:0] snap;
        while ((bi < beats.size() || ei < exps.size()) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (out_valid && ei == stall_idx && st < 5) begin
                out_ready = 1'b0;
                st++;
                if (st == 1) snap = concat_data;
                else chk($sformatf("stall_stable_c%0d", st), {concat_data[511:1], is_header}, {snap[511:1], 1'b1});
            end else begin
                out_ready = 1'b1;
            end
            if (bi < beats.size()) begin
                in_valid = 1'b1;
                in_data  = beats[bi].data;
                in_last  = beats[bi].last;
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
                in_last  = 1'b0;
            end
            #1;
            if (st == 5 && !out_ready) chk("stall_in_ready_low", 512'(in_ready), 512'(0));
            if (in_valid && in_ready) bi++;
            if (out_valid && out_ready) begin
                if (ei < exps.size()) begin
                    chk($sformatf("b%0d_data_hi", ei), 512'(concat_data[511:256]), 512'(exps[ei].data[511:256]));
                    if (exps[ei].chk_lo)
                        chk($sformatf("b%0d_data_lo", ei), 512'(concat_data[255:0]), 512'(exps[ei].data[255:0]));
                    chk($sformatf("b%0d_cursor", ei), 512'(cursor), 512'(exps[ei].cursor));
                    chk($sformatf("b%0d_bitmap", ei), 512'(bitmap), 512'(exps[ei].bitmap));
                    chk($sformatf("b%0d_offsets", ei),
                        512'({offset7, offset6, offset5, offset4, offset3, offset2, offset1}), 512'(exps[ei].offs));
                    chk($sformatf("b%0d_flags", ei), 512'({is_header, need_decomp}), 512'({exps[ei].hdr, exps[ei].nd}));
                end else begin
                    chk("extra_bundle", 512'(1), 512'(0));
                end
                ei++;
            end
        end
        if (cyc >= 2000) chk("run_timeout", 512'(cyc), 512'(0));
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        beats.delete();
        exps.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 512'(out_valid), 512'(0));
        chk({tag, "_in_ready"}, 512'(in_ready), 512'(0));
        chk({tag, "_err"}, 512'(err), 512'(0));
        chk({tag, "_concat"}, concat_data, 512'(0));
        chk({tag, "_cur_bm_flags"}, 512'({cursor, bitmap, is_header, need_decomp}), 512'(0));
        chk({tag, "_offsets"},
            512'({offset7, offset6, offset5, offset4, offset3, offset2, offset1}), 512'(0));
    endtask

    initial begin
        logic [255:0] h, r1, r2, r3, d0, d1, d2, d3, d4, e0;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Raw page: header + 3 beats.
        h  = hdr_beat(1'b0, 16'd5);
        r1 = {8{32'hDEAD_BEEF}};
        r2 = {8{32'h0123_4567}};
        r3 = {8{32'h89AB_CDEF}};
        add_beat(h, 1'b0); add_beat(r1, 1'b0); add_beat(r2, 1'b0); add_beat(r3, 1'b1);
        exps.push_back(e_hdr(h)); exps.push_back(e_raw(r1));
        exps.push_back(e_raw(r2)); exps.push_back(e_raw(r3));
        run(-1);

        // Compressed page, 6 blocks, with a 5-cycle stall on the header bundle.
        h  = hdr_beat(1'b1, 16'd6);
        d0 = {16'hFFFF, {15{16'h1234}}};
        d1 = {16'hABCD, 16'h0FFF, {12{16'h5A5A}}, 16'h0000, 16'hFFFF};
        d2 = {16{16'hC3C3}};
        d3 = {16'h7FFF, {15{16'h2468}}};
        d4 = {16'h0001, {15{16'h1357}}};
        add_beat(h, 1'b0); add_beat(d0, 1'b0); add_beat(d1, 1'b0);
        add_beat(d2, 1'b0); add_beat(d3, 1'b0); add_beat(d4, 1'b1);
        exps.push_back(e_hdr(h));
        exps.push_back(e_blk(d0, d1, 1'b1, 11'd0,   16'hFFFF, offs_step(11'd32, 11'd32)));
        exps.push_back(e_blk(d1, d2, 1'b0, 11'd16,  16'h0FFF,
                             offs7(11'd48, 11'd80, 11'd112, 11'd144, 11'd176, 11'd208, 11'd208)));
        exps.push_back(e_blk(d1, d2, 1'b0, 11'd224, 16'h0000, offs_step(11'd224, 11'd0)));
        exps.push_back(e_blk(d1, d2, 1'b1, 11'd240, 16'hFFFF, offs_step(11'd272, 11'd32)));
        exps.push_back(e_blk(d3, d4, 1'b0, 11'd0,   16'h7FFF, offs_step(11'd32, 11'd32)));
        exps.push_back(e_blk(d4, d4, 1'b0, 11'd0,   16'h0001, offs_step(11'd8, 11'd0)));
        run(0);
        chk("err_after_good_page", 512'(err), 512'(0));

        // Compressed page with N=0: remaining beats dropped.
        h = hdr_beat(1'b1, 16'd0);
        add_beat(h, 1'b0); add_beat(r1, 1'b0); add_beat(r2, 1'b1);
        exps.push_back(e_hdr(h));
        run(-1);

        // Truncated page: second block needs lo but in_last already taken.
        h  = hdr_beat(1'b1, 16'd3);
        e0 = {16'h0000, 16'hFFFF, {14{16'h9999}}};
        add_beat(h, 1'b0); add_beat(e0, 1'b1);
        exps.push_back(e_hdr(h));
        exps.push_back(e_blk(e0, e0, 1'b0, 11'd0, 16'h0000, offs_step(11'd0, 11'd0)));
        run(-1);
        repeat (3) @(negedge clk);
        #1;
        chk("trunc_err_set", 512'(err), 512'(1));
        chk("trunc_back_to_hdr_in_ready", 512'(in_ready), 512'(1));

        // Back in S_HDR: single-beat header page, then a raw page.
        h  = hdr_beat(1'b0, 16'd0);
        r1 = hdr_beat(1'b0, 16'd7);
        add_beat(h, 1'b1); add_beat(r1, 1'b0); add_beat(r3, 1'b1);
        exps.push_back(e_hdr(h)); exps.push_back(e_hdr(r1)); exps.push_back(e_raw(r3));
        run(-1);
        chk("err_sticky", 512'(err), 512'(1));

        // Mid-page asynchronous reset.
        h = hdr_beat(1'b1, 16'd2);
        add_beat(h, 1'b0); add_beat(d0, 1'b0);
        exps.push_back(e_hdr(h));
        run(-1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First beat after reset is a header.
        h = hdr_beat(1'b0, 16'd1);
        add_beat(h, 1'b0); add_beat(r2, 1'b1);
        exps.push_back(e_hdr(h)); exps.push_back(e_raw(r2));
        run(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
